result_storage_mc: RTL and testbench

Multi-channel result capture buffer with per-channel append-only write pointers, a selectable stop-when-full or circular-overwrite mode, and a registered random-access read port. It sits at the output of the processing pipeline and collects result words from up to CHANNELS independent producers. The host register interface later reads them back by channel and logical index. It also reports per-channel fill level, full, and overflow status.

---
 rtl/result_storage_mc.sv | 132 +++++++++++++
 tb/tb_result_storage_mc.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_storage_mc.sv
// result_storage_mc: multi-channel result capture buffer.
// Each channel appends words through its own write pointer into a private
// DEPTH-word region. The channel either stops when full or overwrites its
// oldest word. A registered random-access port reads a word back by channel
// and logical index, where index 0 is the oldest word still stored.

module result_storage_mc #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 13,
  parameter int CHANNELS   = 4,
  parameter int WRAP_MODE  = 0,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CW        = DEPTH_LOG2 + 1
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [CHANNELS-1:0]       CLEAR,
  input  logic [CHANNELS*WIDTH-1:0] DIN,
  input  logic [CHANNELS-1:0]       DIN_WE,
  input  logic                      READ_REQ,
  input  logic [CH_W-1:0]           READ_CH,
  input  logic [DEPTH_LOG2-1:0]     READ_ADDR,
  output logic [WIDTH-1:0]          READ_DOUT,
  output logic                      READ_VALID,
  output logic                      READ_ERR,
  output logic [CHANNELS*CW-1:0]    COUNT,
  output logic [CHANNELS-1:0]       FULL,
  output logic [CHANNELS-1:0]       OVERFLOW
);

  localparam int            DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [CHANNELS*DEPTH_LOG2-1:0] wr_ptr_q;
  logic [CHANNELS*CW-1:0]         count_q;
  logic [CHANNELS-1:0]            ovf_q;
  logic [CHANNELS-1:0]            full_c;
  logic [CHANNELS-1:0]            store_en;
  logic [CHANNELS-1:0]            ovf_evt;
  logic [WIDTH-1:0]               mem [CHANNELS][DEPTH];

  int                    sel_ch;
  logic                  rd_ch_ok;
  logic                  rd_hit;
  logic [DEPTH_LOG2-1:0] sel_ptr;
  logic [DEPTH_LOG2-1:0] rd_phys;
  logic [CW-1:0]         sel_cnt;

  logic [WIDTH-1:0] read_dout_q;
  logic             read_valid_q;
  logic             read_err_q;

  // Decide per channel whether a write is stored, dropped, or overwrites the oldest word
  always_comb begin
    full_c   = '0;
    store_en = '0;
    ovf_evt  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full_c[c] = (count_q[c*CW +: CW] == DEPTH_CNT);
      if (DIN_WE[c] && !CLEAR[c]) begin
        ovf_evt[c]  = full_c[c];
        store_en[c] = !full_c[c] || (WRAP_MODE != 0);
      end
    end
  end

  // Per-channel write pointer, fill count and sticky overflow; clear beats a same-cycle write
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (CLEAR[c]) begin
          wr_ptr_q[c*DEPTH_LOG2 +: DEPTH_LOG2] <= '0;
          count_q[c*CW +: CW]                  <= '0;
          ovf_q[c]                             <= 1'b0;
        end else begin
          if (store_en[c]) begin
            wr_ptr_q[c*DEPTH_LOG2 +: DEPTH_LOG2] <=
              wr_ptr_q[c*DEPTH_LOG2 +: DEPTH_LOG2] + DEPTH_LOG2'(1);
            if (!full_c[c])
              count_q[c*CW +: CW] <= count_q[c*CW +: CW] + CW'(1);
          end
          if (ovf_evt[c])
            ovf_q[c] <= 1'b1;
        end
      end
    end
  end

  // Store accepted words; the memory array itself is never reset
  always_ff @(posedge CLK) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (store_en[c])
        mem[c][wr_ptr_q[c*DEPTH_LOG2 +: DEPTH_LOG2]] <= DIN[c*WIDTH +: WIDTH];
    end
  end

  // Translate the logical index into a physical address using pre-write pointer and count
  always_comb begin
    rd_ch_ok = (32'(READ_CH) < CHANNELS);
    sel_ch   = rd_ch_ok ? int'(READ_CH) : 0;
    sel_ptr  = wr_ptr_q[sel_ch*DEPTH_LOG2 +: DEPTH_LOG2];
    sel_cnt  = count_q[sel_ch*CW +: CW];
    rd_phys  = sel_ptr - sel_cnt[DEPTH_LOG2-1:0] + READ_ADDR;
    rd_hit   = rd_ch_ok && ({1'b0, READ_ADDR} < sel_cnt);
  end

  // Registered read port; data holds between requests and is forced to zero on a miss
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      read_dout_q  <= '0;
      read_valid_q <= 1'b0;
      read_err_q   <= 1'b0;
    end else begin
      read_valid_q <= READ_REQ;
      read_err_q   <= READ_REQ && !rd_hit;
      if (READ_REQ)
        read_dout_q <= rd_hit ? mem[sel_ch][rd_phys] : '0;
    end
  end

  assign READ_DOUT  = read_dout_q;
  assign READ_VALID = read_valid_q;
  assign READ_ERR   = read_err_q;
  assign COUNT      = count_q;
  assign FULL       = full_c;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_result_storage_mc.sv
// tb_result_storage_mc: drives identical stimulus into a stop-when-full and a
// circular instance. It keeps a shift-register reference of each channel's
// logical contents and scoreboards every read result against that reference.

module tb_result_storage_mc;

  localparam int WIDTH = 32;
  localparam int DL    = 3;
  localparam int CH    = 2;
  localparam int CW    = DL + 1;

  logic                clk;
  logic                reset_n;
  logic [CH-1:0]       clear;
  logic [CH*WIDTH-1:0] din;
  logic [CH-1:0]       din_we;
  logic                read_req;
  logic                read_ch;
  logic [DL-1:0]       read_addr;

  logic [WIDTH-1:0] dout_m0, dout_m1;
  logic             valid_m0, valid_m1;
  logic             err_m0, err_m1;
  logic [CH*CW-1:0] count_m0, count_m1;
  logic [CH-1:0]    full_m0, full_m1;
  logic [CH-1:0]    ovf_m0, ovf_m1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_data [2][2][8];
  int          m_size [2][2];
  logic        m_ovf  [2][2];

  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  logic [32:0] e0, e1;
  logic [31:0] last0, last1;
  logic        mon_en;

  result_storage_mc #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .CHANNELS(CH), .WRAP_MODE(0)) dut0 (
    .CLK(clk), .RESET_N(reset_n), .CLEAR(clear), .DIN(din), .DIN_WE(din_we),
    .READ_REQ(read_req), .READ_CH(read_ch), .READ_ADDR(read_addr),
    .READ_DOUT(dout_m0), .READ_VALID(valid_m0), .READ_ERR(err_m0),
    .COUNT(count_m0), .FULL(full_m0), .OVERFLOW(ovf_m0)
  );

  result_storage_mc #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .CHANNELS(CH), .WRAP_MODE(1)) dut1 (
    .CLK(clk), .RESET_N(reset_n), .CLEAR(clear), .DIN(din), .DIN_WE(din_we),
    .READ_REQ(read_req), .READ_CH(read_ch), .READ_ADDR(read_addr),
    .READ_DOUT(dout_m1), .READ_VALID(valid_m1), .READ_ERR(err_m1),
    .COUNT(count_m1), .FULL(full_m1), .OVERFLOW(ovf_m1)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        m_size[m][c] = 0;
        m_ovf[m][c]  = 1'b0;
      end
  endfunction

  function automatic void model_write(int m, int c, logic [31:0] d);
    if (m_size[m][c] < 8) begin
      m_data[m][c][m_size[m][c]] = d;
      m_size[m][c]++;
    end else begin
      m_ovf[m][c] = 1'b1;
      if (m == 1) begin
        for (int i = 0; i < 7; i++) m_data[m][c][i] = m_data[m][c][i+1];
        m_data[m][c][7] = d;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [1:0] we, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] clr, input logic req, input logic ch,
                               input logic [2:0] addr);
    logic [32:0] e;
    din       = {d1, d0};
    din_we    = we;
    clear     = clr;
    read_req  = req;
    read_ch   = ch;
    read_addr = addr;
    if (req) begin
      for (int m = 0; m < 2; m++) begin
        if (int'(addr) < m_size[m][ch]) e = {1'b0, m_data[m][ch][addr]};
        else e = {1'b1, 32'h0};
        if (m == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
      end
    end
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        if (clr[c]) begin
          m_size[m][c] = 0;
          m_ovf[m][c]  = 1'b0;
        end else if (we[c]) begin
          model_write(m, c, (c == 0) ? d0 : d1);
        end
      end
    @(posedge clk);
    #1;
    din_we   = '0;
    clear    = '0;
    read_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic checkState(input string tag);
    logic [CH*CW-1:0] cnt;
    logic [CH-1:0]    fl, ov;
    for (int m = 0; m < 2; m++) begin
      cnt = (m == 0) ? count_m0 : count_m1;
      fl  = (m == 0) ? full_m0 : full_m1;
      ov  = (m == 0) ? ovf_m0 : ovf_m1;
      for (int c = 0; c < 2; c++) begin
        checkOutput($sformatf("%s_cnt_m%0d_c%0d", tag, m, c), 64'(cnt[c*CW +: CW]), 64'(m_size[m][c]));
        checkOutput($sformatf("%s_full_m%0d_c%0d", tag, m, c), 64'(fl[c]), 64'(m_size[m][c] == 8));
        checkOutput($sformatf("%s_ovf_m%0d_c%0d", tag, m, c), 64'(ov[c]), 64'(m_ovf[m][c]));
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cnt_m0"}, 64'(count_m0), 64'(0));
    checkOutput({tag, "_cnt_m1"}, 64'(count_m1), 64'(0));
    checkOutput({tag, "_full"}, 64'({full_m0, full_m1}), 64'(0));
    checkOutput({tag, "_ovf"}, 64'({ovf_m0, ovf_m1}), 64'(0));
    checkOutput({tag, "_valid"}, 64'({valid_m0, valid_m1}), 64'(0));
    checkOutput({tag, "_err"}, 64'({err_m0, err_m1}), 64'(0));
    checkOutput({tag, "_dout_m0"}, 64'(dout_m0), 64'(0));
    checkOutput({tag, "_dout_m1"}, 64'(dout_m1), 64'(0));
  endtask

  // Scoreboard: pop the expected result whenever a DUT presents one, otherwise check data holds
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_m0) begin
        if (exp_q0.size() == 0) checkOutput("unexpected_valid_m0", 64'(1), 64'(0));
        else begin
          e0 = exp_q0.pop_front();
          checkOutput("rd_data_m0", 64'(dout_m0), 64'(e0[31:0]));
          checkOutput("rd_err_m0", 64'(err_m0), 64'(e0[32]));
          last0 = dout_m0;
        end
      end else begin
        checkOutput("hold_m0", 64'(dout_m0), 64'(last0));
      end
      if (valid_m1) begin
        if (exp_q1.size() == 0) checkOutput("unexpected_valid_m1", 64'(1), 64'(0));
        else begin
          e1 = exp_q1.pop_front();
          checkOutput("rd_data_m1", 64'(dout_m1), 64'(e1[31:0]));
          checkOutput("rd_err_m1", 64'(err_m1), 64'(e1[32]));
          last1 = dout_m1;
        end
      end else begin
        checkOutput("hold_m1", 64'(dout_m1), 64'(last1));
      end
    end
  end

  // Main stimulus sequence
  initial begin
    mon_en    = 1'b0;
    last0     = '0;
    last1     = '0;
    reset_n   = 1'b0;
    clear     = '0;
    din       = '0;
    din_we    = '0;
    read_req  = 1'b0;
    read_ch   = 1'b0;
    read_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Five writes on channel 0, then read every index plus one beyond the count
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 32'hA0 + i, 32'h0, 2'b00, 1'b0, 1'b0, 3'd0);
    checkState("fill5");
    checkOutput("fill5_cnt0_m0", 64'(count_m0[3:0]), 64'(5));
    checkOutput("fill5_full0_m0", 64'(full_m0[0]), 64'(0));
    for (int i = 0; i < 6; i++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 3'(i));
    idle(2);

    // Clear both, then overfill both channels with ten words each
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) applyStimulus(2'b11, 32'h10 + i, 32'h10 + i, 2'b00, 1'b0, 1'b0, 3'd0);
    checkState("over");
    checkOutput("over_cnt1_m0", 64'(count_m0[7:4]), 64'(8));
    checkOutput("over_full1_m0", 64'(full_m0[1]), 64'(1));
    checkOutput("over_ovf1_m0", 64'(ovf_m0[1]), 64'(1));
    checkOutput("over_cnt0_m1", 64'(count_m1[3:0]), 64'(8));
    checkOutput("over_ovf0_m1", 64'(ovf_m1[0]), 64'(1));
    for (int i = 0; i < 8; i++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1, 3'(i));
    for (int i = 0; i < 8; i++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 3'(i));
    idle(2);

    // Simultaneous writes on both channels, then clear channel 0 against a write
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 32'h1, 32'h2, 2'b00, 1'b0, 1'b0, 3'd0);
    checkState("dual");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 3'(i));
      applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1, 3'(i));
    end
    idle(2);
    applyStimulus(2'b01, 32'h77, 32'h0, 2'b01, 1'b0, 1'b0, 3'd0);
    checkState("clrwr");
    checkOutput("clrwr_cnt0_m0", 64'(count_m0[3:0]), 64'(0));
    checkOutput("clrwr_cnt1_m0", 64'(count_m0[7:4]), 64'(3));

    // Read in the same cycle as a write, before and after the channel fills
    applyStimulus(2'b01, 32'hB0, 32'h0, 2'b00, 1'b0, 1'b0, 3'd0);
    applyStimulus(2'b01, 32'hB1, 32'h0, 2'b00, 1'b0, 1'b0, 3'd0);
    applyStimulus(2'b01, 32'hB2, 32'h0, 2'b00, 1'b1, 1'b0, 3'd2);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 3'd2);
    for (int i = 3; i < 8; i++) applyStimulus(2'b01, 32'hB0 + i, 32'h0, 2'b00, 1'b0, 1'b0, 3'd0);
    applyStimulus(2'b01, 32'hC0, 32'h0, 2'b00, 1'b1, 1'b0, 3'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 3'd7);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 3'd0);
    idle(2);
    checkState("rdwr");

    // Asynchronous reset while a read result is being presented
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 3'd1);
    checkOutput("prereset_valid_m0", 64'(valid_m0), 64'(1));
    checkOutput("prereset_valid_m1", 64'(valid_m1), 64'(1));
    #1;
    reset_n = 1'b0;
    last0   = '0;
    last1   = '0;
    exp_q0.delete();
    exp_q1.delete();
    model_reset();
    #1;
    checkAllZero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkState("postreset");
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 3'd0);
    idle(2);

    checkOutput("sb_empty_m0", 64'(exp_q0.size()), 64'(0));
    checkOutput("sb_empty_m1", 64'(exp_q1.size()), 64'(0));
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
